wb_write_sequencer: RTL and testbench



---
 rtl/y86_pkg.sv | 26 ++
 rtl/wb_write_sequencer.sv | 113 +++++++++++
 tb/tb_wb_write_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, special register IDs and the
// writeback sequencer state encoding.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef logic [1:0] wb_state_t;
    localparam wb_state_t WB_RUN    = 2'd0;
    localparam wb_state_t WB_SECOND = 2'd1;
    localparam wb_state_t WB_HALTED = 2'd2;

endpackage

// File: rtl/wb_write_sequencer.sv
// Writeback controller: serialises the E and M writes of one instruction onto
// a single register-file port, parks the pipeline on HALT and counts retirements.
module wb_write_sequencer
    import y86_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       W_dstE,
    input  logic [63:0]      W_valE,
    input  logic [3:0]       W_dstM,
    input  logic [63:0]      W_valM,
    output logic             rf_we,
    output logic [3:0]       rf_waddr,
    output logic [63:0]      rf_wdata,
    output logic             W_stall,
    output logic             pipe_stall,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [1:0]       dbg_state
);

    wb_state_t        state_q, state_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        has_e, has_m;
    logic        we_c, stall_c, leave_c, retire_c;
    logic [3:0]  waddr_c;
    logic [63:0] wdata_c;

    assign has_e = (W_dstE != RNONE);
    assign has_m = (W_dstM != RNONE);

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        we_c     = 1'b0;
        waddr_c  = 4'h0;
        wdata_c  = 64'h0;
        stall_c  = 1'b0;
        leave_c  = 1'b0;
        case (state_q)
            WB_RUN: begin
                if (W_icode == ICODE_HALT) begin
                    stall_c  = 1'b1;
                    state_d  = WB_HALTED;
                    halted_d = 1'b1;
                end else if (has_e && has_m && (W_dstE != W_dstM)) begin
                    we_c    = 1'b1;
                    waddr_c = W_dstE;
                    wdata_c = W_valE;
                    stall_c = 1'b1;
                    state_d = WB_SECOND;
                end else if (has_m) begin
                    // Also covers dstE == dstM (popq %rsp): the loaded value wins.
                    we_c    = 1'b1;
                    waddr_c = W_dstM;
                    wdata_c = W_valM;
                    leave_c = 1'b1;
                end else if (has_e) begin
                    we_c    = 1'b1;
                    waddr_c = W_dstE;
                    wdata_c = W_valE;
                    leave_c = 1'b1;
                end else begin
                    leave_c = 1'b1;
                end
            end
            WB_SECOND: begin
                we_c    = 1'b1;
                waddr_c = W_dstM;
                wdata_c = W_valM;
                leave_c = 1'b1;
                state_d = WB_RUN;
            end
            WB_HALTED: begin
                stall_c = 1'b1;
            end
            default: begin
                state_d = WB_RUN;
            end
        endcase
    end

    assign retire_c = leave_c && (W_icode != ICODE_NOP) && (W_icode != ICODE_HALT);
    assign cnt_d    = retire_c ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= WB_RUN;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    // Reset masks the combinational outputs so a pending M write cannot leak out.
    assign rf_we       = we_c & ~reset;
    assign rf_waddr    = rf_we ? waddr_c : 4'h0;
    assign rf_wdata    = rf_we ? wdata_c : 64'h0;
    assign W_stall     = stall_c & ~reset;
    assign pipe_stall  = W_stall;
    assign halted      = halted_q;
    assign retired_cnt = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Directed and random checks of the writeback sequencer against a per-instruction
// write-list model; a second instance with a 4-bit counter exercises wrap-around.
module tb_wb_write_sequencer;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  W_icode = ICODE_NOP;
    logic [3:0]  W_dstE = RNONE;
    logic [63:0] W_valE = '0;
    logic [3:0]  W_dstM = RNONE;
    logic [63:0] W_valM = '0;

    logic        rf_we, rf_we4;
    logic [3:0]  rf_waddr, rf_waddr4;
    logic [63:0] rf_wdata, rf_wdata4;
    logic        W_stall, W_stall4, pipe_stall, pipe_stall4, halted, halted4;
    logic [63:0] retired_cnt;
    logic [3:0]  retired_cnt4;
    logic [1:0]  dbg_state, dbg_state4;

    int total = 0;
    int bad = 0;
    logic [63:0] model_cnt = '0;
    logic [69:0] exp_q[$];

    wb_write_sequencer #(.CNT_W(64)) dut (
        .clk(clk), .reset(reset), .W_icode(W_icode), .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .W_stall(W_stall), .pipe_stall(pipe_stall),
        .halted(halted), .retired_cnt(retired_cnt), .dbg_state(dbg_state)
    );

    wb_write_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .W_icode(W_icode), .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM), .rf_we(rf_we4), .rf_waddr(rf_waddr4),
        .rf_wdata(rf_wdata4), .W_stall(W_stall4), .pipe_stall(pipe_stall4),
        .halted(halted4), .retired_cnt(retired_cnt4), .dbg_state(dbg_state4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [69:0] ent(input logic st, input logic we,
                                        input logic [3:0] a, input logic [63:0] d);
        return {st, we, a, d};
    endfunction

    task automatic check_counts(input string tag, input logic exp_halted);
        check({tag, ".cnt"}, 70'(retired_cnt), 70'(model_cnt));
        check({tag, ".cnt4"}, 70'(retired_cnt4), 70'(model_cnt[3:0]));
        check({tag, ".halted"}, 70'({halted, halted4}), 70'({exp_halted, exp_halted}));
    endtask

    // One list entry per clock the instruction spends in W: {stall, we, addr, data}.
    task automatic plan(input logic [3:0] ic, input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
        exp_q.delete();
        if (ic == ICODE_HALT) exp_q.push_back(ent(1'b1, 1'b0, 4'h0, 64'h0));
        else if (de != RNONE && dm != RNONE && de != dm) begin
            exp_q.push_back(ent(1'b1, 1'b1, de, ve));
            exp_q.push_back(ent(1'b0, 1'b1, dm, vm));
        end else if (dm != RNONE) exp_q.push_back(ent(1'b0, 1'b1, dm, vm));
        else if (de != RNONE) exp_q.push_back(ent(1'b0, 1'b1, de, ve));
        else exp_q.push_back(ent(1'b0, 1'b0, 4'h0, 64'h0));
    endtask

    task automatic run_instr(input string tag, input logic [3:0] ic, input logic [3:0] de,
                             input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
        logic [69:0] e;
        W_icode = ic; W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
        plan(ic, de, ve, dm, vm);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            check({tag, ".wb"}, {W_stall, rf_we, rf_waddr, rf_wdata}, e);
            check({tag, ".wb4"}, {W_stall4, rf_we4, rf_waddr4, rf_wdata4}, e);
            check({tag, ".pipe"}, 70'({pipe_stall, pipe_stall4}), 70'({e[69], e[69]}));
            @(posedge clk); #1;
        end
        if (ic != ICODE_NOP && ic != ICODE_HALT) model_cnt = model_cnt + 64'd1;
        check_counts(tag, ic == ICODE_HALT);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        model_cnt = '0;
        check({tag, ".out"}, 70'({rf_we, W_stall, pipe_stall, rf_waddr, rf_wdata}), 70'(0));
        check_counts(tag, 1'b0);
        check({tag, ".state"}, 70'(dbg_state), 70'(WB_RUN));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] ic, de, dm;
        do_reset("reset");

        for (int i = 0; i < 40; i++) begin
            ic = 4'($urandom_range(1, 11));
            de = ($urandom_range(0, 2) == 0) ? RNONE : 4'($urandom_range(0, 14));
            dm = ($urandom_range(0, 3) == 0) ? de :
                 (($urandom_range(0, 1) == 0) ? RNONE : 4'($urandom_range(0, 14)));
            run_instr("rand", ic, de, {$urandom, $urandom}, dm, {$urandom, $urandom});
        end

        run_instr("popq_rbx", ICODE_POPQ, RRSP, 64'h108, 4'h3, 64'h55);
        run_instr("popq_rsp", ICODE_POPQ, RRSP, 64'h108, RRSP, 64'hAA);
        run_instr("irmovq", ICODE_IRMOVQ, 4'h2, 64'h7, RNONE, 64'h0);
        run_instr("bubble", ICODE_NOP, RNONE, 64'h0, RNONE, 64'h0);

        do_reset("reset_wrap");
        for (int i = 0; i < 17; i++)
            run_instr("wrap", ICODE_IRMOVQ, 4'($urandom_range(0, 14)), {$urandom, $urandom},
                      RNONE, 64'h0);
        check("wrap.cnt4_is_1", 70'(retired_cnt4), 70'(1));

        W_icode = ICODE_POPQ; W_dstE = RRSP; W_valE = 64'h108; W_dstM = 4'h3; W_valM = 64'h55;
        @(negedge clk);
        check("midsec.first", {W_stall, rf_we, rf_waddr, rf_wdata}, ent(1'b1, 1'b1, RRSP, 64'h108));
        @(posedge clk); #1;
        check("midsec.in_second", 70'(dbg_state), 70'(WB_SECOND));
        reset = 1'b1;
        #1;
        model_cnt = '0;
        check("midsec.dropped", 70'({rf_we, W_stall, rf_waddr, rf_wdata}), 70'(0));
        check_counts("midsec", 1'b0);
        check("midsec.state", 70'(dbg_state), 70'(WB_RUN));
        W_icode = ICODE_NOP; W_dstE = RNONE; W_dstM = RNONE;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midsec.release", 70'({rf_we, W_stall, dbg_state}), 70'({1'b0, 1'b0, WB_RUN}));
        @(posedge clk); #1;
        check_counts("midsec.after", 1'b0);

        run_instr("pre_halt", ICODE_OPQ, 4'h1, 64'h1234, RNONE, 64'h0);
        run_instr("halt", ICODE_HALT, RNONE, 64'h0, RNONE, 64'h0);
        for (int i = 0; i < 12; i++) begin
            W_icode = 4'($urandom_range(0, 15));
            W_dstE = 4'($urandom_range(0, 15));
            W_dstM = 4'($urandom_range(0, 15));
            W_valE = {$urandom, $urandom};
            W_valM = {$urandom, $urandom};
            @(negedge clk);
            check("halted.out", 70'({rf_we, W_stall, pipe_stall, rf_waddr, rf_wdata}),
                  70'({1'b0, 1'b1, 1'b1, 4'h0, 64'h0}));
            @(posedge clk); #1;
            check_counts("halted", 1'b1);
        end
        check("halted.state", 70'(dbg_state), 70'(WB_HALTED));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
